// File: rtl/ticket_issue_scheduler.sv
// ticket_issue_scheduler
//   Shares one ticket printer and three route stock counters between N_KIOSK kiosks.
//   Round-robin picks a requester, CHECK reserves stock, PRINT/WAIT run the printer
//   handshake, a WAIT timeout puts the reserved stock back, RESP acks the winner.
//   An admin restock path can add one ticket to any route in any state.
// Ports
//   clk_i, reset_n_i               clock, synchronous active-low reset
//   req_i/req_route_i/req_qty_i    per-kiosk request level, route (2b each), quantity
//   ack_o, ack_ok_o                one-hot completion pulse and its success flag
//   busy_o                         high whenever not idle
//   prn_valid_o/route_o/qty_o      print command towards the printer
//   prn_ready_i, prn_done_i        printer accept and print-finished pulse
//   restock_i/restock_route_i/admin_ok_i  admin +1 restock
//   stock0_o..stock2_o             live stock per route
//   timeout_err_o                  sticky print-timeout flag
module ticket_issue_scheduler #(
  parameter int unsigned N_KIOSK    = 3,
  parameter int unsigned QTY_W      = 3,
  parameter int unsigned STOCK_W    = 3,
  parameter int unsigned STOCK_INIT = 7,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [N_KIOSK-1:0]         req_i,
  input  logic [2*N_KIOSK-1:0]       req_route_i,
  input  logic [QTY_W*N_KIOSK-1:0]   req_qty_i,
  output logic [N_KIOSK-1:0]         ack_o,
  output logic                       ack_ok_o,
  output logic                       busy_o,
  output logic                       prn_valid_o,
  output logic [1:0]                 prn_route_o,
  output logic [QTY_W-1:0]           prn_qty_o,
  input  logic                       prn_ready_i,
  input  logic                       prn_done_i,
  input  logic                       restock_i,
  input  logic [1:0]                 restock_route_i,
  input  logic                       admin_ok_i,
  output logic [STOCK_W-1:0]         stock0_o,
  output logic [STOCK_W-1:0]         stock1_o,
  output logic [STOCK_W-1:0]         stock2_o,
  output logic                       timeout_err_o
);

  localparam int unsigned IW = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  // Wide enough for stock + restore + restock without overflow.
  localparam int unsigned CW = ((QTY_W > STOCK_W) ? QTY_W : STOCK_W) + 1;
  localparam logic [CW-1:0] StockMax = CW'(2 ** STOCK_W - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCheck = 3'd1;
  localparam logic [2:0] StPrint = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      win_q, win_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [1:0]         route_q, route_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic               ok_q, ok_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               prn_valid_q, prn_valid_d;
  logic [1:0]         prn_route_q, prn_route_d;
  logic [QTY_W-1:0]   prn_qty_q, prn_qty_d;
  logic               timeout_err_q, timeout_err_d;
  logic [STOCK_W-1:0] stock_q [3];
  logic [STOCK_W-1:0] stock_d [3];
  logic [CW-1:0]      stock_sum [3];

  logic               found;
  logic [IW-1:0]      grant_id;
  logic [1:0]         grant_route;
  logic [QTY_W-1:0]   grant_qty;
  logic [STOCK_W-1:0] cur_stock;
  logic               dec_en, inc_en;

  // Round-robin: the second pass (indices >= rr_q) overrides the wrap-around pass.
  always_comb begin
    found       = 1'b0;
    grant_id    = '0;
    grant_route = '0;
    grant_qty   = '0;
    for (int i = N_KIOSK - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found       = 1'b1;
        grant_id    = IW'(i);
        grant_route = req_route_i[2*i +: 2];
        grant_qty   = req_qty_i[QTY_W*i +: QTY_W];
      end
    end
    for (int i = N_KIOSK - 1; i >= 0; i--) begin
      if (req_i[i] && (i >= int'(rr_q))) begin
        grant_id    = IW'(i);
        grant_route = req_route_i[2*i +: 2];
        grant_qty   = req_qty_i[QTY_W*i +: QTY_W];
      end
    end
  end

  always_comb begin
    case (route_q)
      2'd0:    cur_stock = stock_q[0];
      2'd1:    cur_stock = stock_q[1];
      2'd2:    cur_stock = stock_q[2];
      default: cur_stock = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    rr_d          = rr_q;
    route_d       = route_q;
    qty_d         = qty_q;
    ok_d          = ok_q;
    timer_d       = timer_q;
    prn_valid_d   = prn_valid_q;
    prn_route_d   = prn_route_q;
    prn_qty_d     = prn_qty_q;
    timeout_err_d = timeout_err_q;
    dec_en        = 1'b0;
    inc_en        = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = grant_id;
          route_d = grant_route;
          qty_d   = grant_qty;
          rr_d    = (grant_id == IW'(N_KIOSK - 1)) ? '0 : grant_id + 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if ((route_q == 2'd3) || (qty_q == '0) || (CW'(cur_stock) < CW'(qty_q))) begin
          ok_d    = 1'b0;
          state_d = StResp;
        end else begin
          dec_en      = 1'b1;
          prn_valid_d = 1'b1;
          prn_route_d = route_q;
          prn_qty_d   = qty_q;
          state_d     = StPrint;
        end
      end
      StPrint: begin
        if (prn_ready_i) begin
          prn_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A done on the final cycle still counts as success.
        if (prn_done_i) begin
          ok_d    = 1'b1;
          state_d = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          inc_en        = 1'b1;
          timeout_err_d = 1'b1;
          ok_d          = 1'b0;
          state_d       = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Net stock update: restock, CHECK decrement and timeout restore may coincide.
  // The decrement is only issued when stock >= qty, so the sum cannot go negative.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      stock_sum[r] = CW'(stock_q[r]);
      if (restock_i && admin_ok_i && (restock_route_i == 2'(r))) begin
        stock_sum[r] = stock_sum[r] + 1'b1;
      end
      if (inc_en && (route_q == 2'(r))) begin
        stock_sum[r] = stock_sum[r] + CW'(qty_q);
      end
      if (dec_en && (route_q == 2'(r))) begin
        stock_sum[r] = stock_sum[r] - CW'(qty_q);
      end
      stock_d[r] = (stock_sum[r] > StockMax) ? StockMax[STOCK_W-1:0]
                                             : stock_sum[r][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      win_q         <= '0;
      rr_q          <= '0;
      route_q       <= '0;
      qty_q         <= '0;
      ok_q          <= 1'b0;
      timer_q       <= '0;
      prn_valid_q   <= 1'b0;
      prn_route_q   <= '0;
      prn_qty_q     <= '0;
      timeout_err_q <= 1'b0;
      for (int r = 0; r < 3; r++) stock_q[r] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      rr_q          <= rr_d;
      route_q       <= route_d;
      qty_q         <= qty_d;
      ok_q          <= ok_d;
      timer_q       <= timer_d;
      prn_valid_q   <= prn_valid_d;
      prn_route_q   <= prn_route_d;
      prn_qty_q     <= prn_qty_d;
      timeout_err_q <= timeout_err_d;
      for (int r = 0; r < 3; r++) stock_q[r] <= stock_d[r];
    end
  end

  always_comb begin
    for (int i = 0; i < N_KIOSK; i++) begin
      ack_o[i] = (state_q == StResp) && (win_q == IW'(i));
    end
  end

  assign ack_ok_o      = (state_q == StResp) && ok_q;
  assign busy_o        = (state_q != StIdle);
  assign prn_valid_o   = prn_valid_q;
  assign prn_route_o   = prn_route_q;
  assign prn_qty_o     = prn_qty_q;
  assign stock0_o      = stock_q[0];
  assign stock1_o      = stock_q[1];
  assign stock2_o      = stock_q[2];
  assign timeout_err_o = timeout_err_q;

endmodule
